// File: rtl/issue_dispatch_buf.sv
// Issue/dispatch buffer: captures one decoded instruction, resolves its
// operands (x0, register file, ROB, CDB snoop), writes ROB bypass values
// for instructions that complete at issue, renames the destination in the
// producer table, and holds the result in a one-entry dispatch register
// with a valid/ready handshake toward the reservation stations.
//
// Ports:
//   clk, rst (sync, active-low), flush
//   dec_*            decoded instruction in, dec_ready handshake out (comb)
//   rs1/rs2_addr     register-file read addresses (comb)
//   rf_*, prod_*, rob_*  operand sources for the addressed registers
//   cdb_*            NUM_CDB packed result buses
//   rs/br/ld_ready   downstream station ready
//   disp_*           registered dispatch entry
//   rob_wr_*         one-cycle ROB bypass write
//   prod_en/rd/tag   one-cycle producer-table update
module issue_dispatch_buf #(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned TAG_W    = 4,
    parameter int unsigned NUM_CDB  = 2,
    parameter int unsigned ALU_OP_W = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        flush,
    input  logic                        dec_valid,
    output logic                        dec_ready,
    input  logic [1:0]                  dec_fu_sel,
    input  logic [2:0]                  dec_op_sel,
    input  logic [XLEN-1:0]             dec_pc,
    input  logic [XLEN-1:0]             dec_imm,
    input  logic [4:0]                  dec_rs1,
    input  logic [4:0]                  dec_rs2,
    input  logic [4:0]                  dec_rd,
    input  logic [ALU_OP_W-1:0]         dec_alu_op,
    input  logic [TAG_W-1:0]            dec_rob_tag,
    output logic [4:0]                  rs1_addr,
    output logic [4:0]                  rs2_addr,
    input  logic [XLEN-1:0]             rf_rs1_value,
    input  logic [XLEN-1:0]             rf_rs2_value,
    input  logic                        prod_rs1_valid,
    input  logic                        prod_rs2_valid,
    input  logic [TAG_W-1:0]            prod_rs1_tag,
    input  logic [TAG_W-1:0]            prod_rs2_tag,
    input  logic                        rob_rs1_valid,
    input  logic                        rob_rs2_valid,
    input  logic [XLEN-1:0]             rob_rs1_value,
    input  logic [XLEN-1:0]             rob_rs2_value,
    input  logic [NUM_CDB-1:0]          cdb_valid,
    input  logic [NUM_CDB*TAG_W-1:0]    cdb_tag,
    input  logic [NUM_CDB*XLEN-1:0]     cdb_value,
    input  logic                        rs_ready,
    input  logic                        br_ready,
    input  logic                        ld_ready,
    output logic                        disp_valid,
    output logic [1:0]                  disp_fu_sel,
    output logic [2:0]                  disp_op_sel,
    output logic [ALU_OP_W-1:0]         disp_alu_op,
    output logic [TAG_W-1:0]            disp_tag,
    output logic [XLEN-1:0]             disp_rs1_value,
    output logic [XLEN-1:0]             disp_rs2_value,
    output logic                        disp_rs1_rdy,
    output logic                        disp_rs2_rdy,
    output logic [TAG_W-1:0]            disp_rs1_q,
    output logic [TAG_W-1:0]            disp_rs2_q,
    output logic [XLEN-1:0]             disp_offset,
    output logic [XLEN-1:0]             disp_pc,
    output logic                        disp_br_comp,
    output logic                        rob_wr_en,
    output logic [XLEN-1:0]             rob_wr_value,
    output logic [4:0]                  rob_wr_dest,
    output logic                        prod_en,
    output logic [4:0]                  prod_rd,
    output logic [TAG_W-1:0]            prod_tag
);

    localparam logic [1:0] FU_NONE   = 2'd0;
    localparam logic [1:0] FU_ALU    = 2'd1;
    localparam logic [1:0] FU_BRANCH = 2'd2;
    localparam logic [1:0] FU_LDST   = 2'd3;

    localparam logic [2:0] OP_IMM    = 3'd0;
    localparam logic [2:0] OP_R      = 3'd1;
    localparam logic [2:0] OP_JAL    = 3'd2;
    localparam logic [2:0] OP_JALR   = 3'd3;
    localparam logic [2:0] OP_BRANCH = 3'd4;
    localparam logic [2:0] OP_LOAD   = 3'd5;
    localparam logic [2:0] OP_STORE  = 3'd6;
    localparam logic [2:0] OP_LUI    = 3'd7;

    typedef struct packed {
        logic             rdy;
        logic [TAG_W-1:0] q;
        logic [XLEN-1:0]  val;
    } opnd_t;

    // Lowest-index valid bus whose tag matches wins.
    function automatic opnd_t cdb_lookup(
        input logic [TAG_W-1:0]         tag,
        input logic [NUM_CDB-1:0]       cv,
        input logic [NUM_CDB*TAG_W-1:0] ct,
        input logic [NUM_CDB*XLEN-1:0]  cval
    );
        opnd_t r;
        r     = '0;
        r.q   = tag;
        for (int i = int'(NUM_CDB) - 1; i >= 0; i--) begin
            if (cv[i] && (ct[i*TAG_W +: TAG_W] == tag)) begin
                r.rdy = 1'b1;
                r.q   = '0;
                r.val = cval[i*XLEN +: XLEN];
            end
        end
        return r;
    endfunction

    // Operand priority: x0, architectural RF, finished ROB entry, CDB, else wait.
    function automatic opnd_t resolve(
        input logic [4:0]               addr,
        input logic                     pv,
        input logic [XLEN-1:0]          rfv,
        input logic [TAG_W-1:0]         ptag,
        input logic                     rv,
        input logic [XLEN-1:0]          robv,
        input logic [NUM_CDB-1:0]       cv,
        input logic [NUM_CDB*TAG_W-1:0] ct,
        input logic [NUM_CDB*XLEN-1:0]  cval
    );
        opnd_t r;
        r = '0;
        if (addr == 5'd0) begin
            r.rdy = 1'b1;
        end else if (pv) begin
            r.rdy = 1'b1;
            r.val = rfv;
        end else if (rv) begin
            r.rdy = 1'b1;
            r.val = robv;
        end else begin
            r = cdb_lookup(ptag, cv, ct, cval);
        end
        return r;
    endfunction

    logic            sel_ready;
    logic            accept;
    logic            capture;
    logic            rs1_checked;
    logic            rs2_checked;
    opnd_t           cap_rs1;
    opnd_t           cap_rs2;
    opnd_t           snp_rs1;
    opnd_t           snp_rs2;
    logic            byp_en;
    logic [XLEN-1:0] byp_value;
    logic            prod_upd;

    // Handshake and RF address path.
    always_comb begin
        sel_ready = 1'b1;
        case (disp_fu_sel)
            FU_ALU:    sel_ready = rs_ready;
            FU_BRANCH: sel_ready = br_ready;
            FU_LDST:   sel_ready = ld_ready;
            default:   sel_ready = 1'b1;
        endcase
        accept    = disp_valid & sel_ready;
        dec_ready = rst & ~flush & (~disp_valid | accept);
        capture   = dec_valid & dec_ready;
        rs1_addr  = rst ? dec_rs1 : 5'd0;
        rs2_addr  = rst ? dec_rs2 : 5'd0;
    end

    // Operand selection for the incoming instruction and snoop for the held one.
    always_comb begin
        rs1_checked = (dec_op_sel != OP_JAL) && (dec_op_sel != OP_LUI);
        rs2_checked = (dec_op_sel == OP_R) || (dec_op_sel == OP_BRANCH) ||
                      (dec_op_sel == OP_STORE);

        cap_rs1 = '0;
        if (rs1_checked) begin
            cap_rs1 = resolve(dec_rs1, prod_rs1_valid, rf_rs1_value, prod_rs1_tag,
                              rob_rs1_valid, rob_rs1_value, cdb_valid, cdb_tag, cdb_value);
        end else begin
            cap_rs1.rdy = 1'b1;
            cap_rs1.val = (dec_op_sel == OP_JAL) ? dec_pc : '0;
        end

        cap_rs2 = '0;
        if (rs2_checked) begin
            cap_rs2 = resolve(dec_rs2, prod_rs2_valid, rf_rs2_value, prod_rs2_tag,
                              rob_rs2_valid, rob_rs2_value, cdb_valid, cdb_tag, cdb_value);
        end else begin
            cap_rs2.rdy = 1'b1;
            cap_rs2.val = dec_imm;
        end

        snp_rs1 = cdb_lookup(disp_rs1_q, cdb_valid, cdb_tag, cdb_value);
        snp_rs2 = cdb_lookup(disp_rs2_q, cdb_valid, cdb_tag, cdb_value);
    end

    // ROB bypass (instructions finished at issue) and producer-table rename.
    always_comb begin
        byp_en   = (dec_fu_sel == FU_NONE) || (dec_op_sel == OP_JAL) ||
                   (dec_op_sel == OP_JALR);
        prod_upd = (dec_rd != 5'd0) && (dec_op_sel != OP_BRANCH) &&
                   (dec_op_sel != OP_STORE);
        case (dec_op_sel)
            OP_JAL, OP_JALR: byp_value = dec_pc + XLEN'(4);
            OP_LUI:          byp_value = dec_imm;
            default:         byp_value = dec_pc + dec_imm;
        endcase
    end

    // Dispatch register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            disp_valid     <= 1'b0;
            disp_fu_sel    <= '0;
            disp_op_sel    <= '0;
            disp_alu_op    <= '0;
            disp_tag       <= '0;
            disp_rs1_value <= '0;
            disp_rs2_value <= '0;
            disp_rs1_rdy   <= 1'b0;
            disp_rs2_rdy   <= 1'b0;
            disp_rs1_q     <= '0;
            disp_rs2_q     <= '0;
            disp_offset    <= '0;
            disp_pc        <= '0;
            disp_br_comp   <= 1'b0;
            rob_wr_en      <= 1'b0;
            rob_wr_value   <= '0;
            rob_wr_dest    <= '0;
            prod_en        <= 1'b0;
            prod_rd        <= '0;
            prod_tag       <= '0;
        end else begin
            rob_wr_en <= 1'b0;
            prod_en   <= 1'b0;
            if (flush) begin
                disp_valid <= 1'b0;
            end else if (capture) begin
                // fu NONE completes entirely through the ROB bypass.
                disp_valid     <= (dec_fu_sel != FU_NONE);
                disp_fu_sel    <= dec_fu_sel;
                disp_op_sel    <= dec_op_sel;
                disp_alu_op    <= dec_alu_op;
                disp_tag       <= dec_rob_tag;
                disp_rs1_value <= cap_rs1.val;
                disp_rs1_rdy   <= cap_rs1.rdy;
                disp_rs1_q     <= cap_rs1.q;
                disp_rs2_value <= cap_rs2.val;
                disp_rs2_rdy   <= cap_rs2.rdy;
                disp_rs2_q     <= cap_rs2.q;
                disp_offset    <= ((dec_op_sel == OP_STORE) || (dec_op_sel == OP_BRANCH))
                                  ? dec_imm : '0;
                disp_pc        <= dec_pc;
                disp_br_comp   <= (dec_op_sel == OP_BRANCH);
                rob_wr_en      <= byp_en;
                if (byp_en) begin
                    rob_wr_value <= byp_value;
                    rob_wr_dest  <= dec_rd;
                end
                prod_en <= prod_upd;
                if (prod_upd) begin
                    prod_rd  <= dec_rd;
                    prod_tag <= dec_rob_tag;
                end
            end else if (accept) begin
                disp_valid <= 1'b0;
            end else if (disp_valid) begin
                // Held entry keeps listening for its missing operands.
                if (!disp_rs1_rdy && snp_rs1.rdy) begin
                    disp_rs1_value <= snp_rs1.val;
                    disp_rs1_rdy   <= 1'b1;
                end
                if (!disp_rs2_rdy && snp_rs2.rdy) begin
                    disp_rs2_value <= snp_rs2.val;
                    disp_rs2_rdy   <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_issue_dispatch_buf.sv
// Directed bench for issue_dispatch_buf: reset, ALU/R-type capture,
// held CDB snoop, CDB priority, ROB bypass, store/branch, back-pressure,
// flush and mid-hold reset.
module tb_issue_dispatch_buf;

    localparam int unsigned XLEN     = 32;
    localparam int unsigned TAG_W    = 4;
    localparam int unsigned NUM_CDB  = 2;
    localparam int unsigned ALU_OP_W = 4;

    logic                     clk;
    logic                     rst;
    logic                     flush;
    logic                     dec_valid;
    logic                     dec_ready;
    logic [1:0]               dec_fu_sel;
    logic [2:0]               dec_op_sel;
    logic [XLEN-1:0]          dec_pc;
    logic [XLEN-1:0]          dec_imm;
    logic [4:0]               dec_rs1;
    logic [4:0]               dec_rs2;
    logic [4:0]               dec_rd;
    logic [ALU_OP_W-1:0]      dec_alu_op;
    logic [TAG_W-1:0]         dec_rob_tag;
    logic [4:0]               rs1_addr;
    logic [4:0]               rs2_addr;
    logic [XLEN-1:0]          rf_rs1_value;
    logic [XLEN-1:0]          rf_rs2_value;
    logic                     prod_rs1_valid;
    logic                     prod_rs2_valid;
    logic [TAG_W-1:0]         prod_rs1_tag;
    logic [TAG_W-1:0]         prod_rs2_tag;
    logic                     rob_rs1_valid;
    logic                     rob_rs2_valid;
    logic [XLEN-1:0]          rob_rs1_value;
    logic [XLEN-1:0]          rob_rs2_value;
    logic [NUM_CDB-1:0]       cdb_valid;
    logic [NUM_CDB*TAG_W-1:0] cdb_tag;
    logic [NUM_CDB*XLEN-1:0]  cdb_value;
    logic                     rs_ready;
    logic                     br_ready;
    logic                     ld_ready;
    logic                     disp_valid;
    logic [1:0]               disp_fu_sel;
    logic [2:0]               disp_op_sel;
    logic [ALU_OP_W-1:0]      disp_alu_op;
    logic [TAG_W-1:0]         disp_tag;
    logic [XLEN-1:0]          disp_rs1_value;
    logic [XLEN-1:0]          disp_rs2_value;
    logic                     disp_rs1_rdy;
    logic                     disp_rs2_rdy;
    logic [TAG_W-1:0]         disp_rs1_q;
    logic [TAG_W-1:0]         disp_rs2_q;
    logic [XLEN-1:0]          disp_offset;
    logic [XLEN-1:0]          disp_pc;
    logic                     disp_br_comp;
    logic                     rob_wr_en;
    logic [XLEN-1:0]          rob_wr_value;
    logic [4:0]               rob_wr_dest;
    logic                     prod_en;
    logic [4:0]               prod_rd;
    logic [TAG_W-1:0]         prod_tag;

    int total = 0;
    int bad   = 0;

    issue_dispatch_buf #(
        .XLEN(XLEN), .TAG_W(TAG_W), .NUM_CDB(NUM_CDB), .ALU_OP_W(ALU_OP_W)
    ) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .dec_valid(dec_valid), .dec_ready(dec_ready),
        .dec_fu_sel(dec_fu_sel), .dec_op_sel(dec_op_sel),
        .dec_pc(dec_pc), .dec_imm(dec_imm),
        .dec_rs1(dec_rs1), .dec_rs2(dec_rs2), .dec_rd(dec_rd),
        .dec_alu_op(dec_alu_op), .dec_rob_tag(dec_rob_tag),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rf_rs1_value(rf_rs1_value), .rf_rs2_value(rf_rs2_value),
        .prod_rs1_valid(prod_rs1_valid), .prod_rs2_valid(prod_rs2_valid),
        .prod_rs1_tag(prod_rs1_tag), .prod_rs2_tag(prod_rs2_tag),
        .rob_rs1_valid(rob_rs1_valid), .rob_rs2_valid(rob_rs2_valid),
        .rob_rs1_value(rob_rs1_value), .rob_rs2_value(rob_rs2_value),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
        .rs_ready(rs_ready), .br_ready(br_ready), .ld_ready(ld_ready),
        .disp_valid(disp_valid), .disp_fu_sel(disp_fu_sel),
        .disp_op_sel(disp_op_sel), .disp_alu_op(disp_alu_op),
        .disp_tag(disp_tag),
        .disp_rs1_value(disp_rs1_value), .disp_rs2_value(disp_rs2_value),
        .disp_rs1_rdy(disp_rs1_rdy), .disp_rs2_rdy(disp_rs2_rdy),
        .disp_rs1_q(disp_rs1_q), .disp_rs2_q(disp_rs2_q),
        .disp_offset(disp_offset), .disp_pc(disp_pc),
        .disp_br_comp(disp_br_comp),
        .rob_wr_en(rob_wr_en), .rob_wr_value(rob_wr_value),
        .rob_wr_dest(rob_wr_dest),
        .prod_en(prod_en), .prod_rd(prod_rd), .prod_tag(prod_tag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs are changed and outputs sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_inputs();
        flush = 1'b0; dec_valid = 1'b0; dec_fu_sel = '0; dec_op_sel = '0;
        dec_pc = '0; dec_imm = '0; dec_rs1 = '0; dec_rs2 = '0; dec_rd = '0;
        dec_alu_op = '0; dec_rob_tag = '0;
        rf_rs1_value = '0; rf_rs2_value = '0;
        prod_rs1_valid = 1'b0; prod_rs2_valid = 1'b0;
        prod_rs1_tag = '0; prod_rs2_tag = '0;
        rob_rs1_valid = 1'b0; rob_rs2_valid = 1'b0;
        rob_rs1_value = '0; rob_rs2_value = '0;
        cdb_valid = '0; cdb_tag = '0; cdb_value = '0;
        rs_ready = 1'b0; br_ready = 1'b0; ld_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b0;
        clr_inputs();
        dec_rs1 = 5'd5;
        dec_rs2 = 5'd9;
        #1;
        step();
        step();
        // Reset state
        chk("rst_disp_valid", 64'(disp_valid), 64'd0);
        chk("rst_rob_wr_en",  64'(rob_wr_en),  64'd0);
        chk("rst_prod_en",    64'(prod_en),    64'd0);
        chk("rst_rs1_addr",   64'(rs1_addr),   64'd0);
        chk("rst_rs2_addr",   64'(rs2_addr),   64'd0);
        chk("rst_dec_ready",  64'(dec_ready),  64'd0);
        chk("rst_rs1_value",  64'(disp_rs1_value), 64'd0);
        rst = 1'b1;
        step();

        // ADDI x3, x5, 3
        dec_valid = 1'b1; dec_fu_sel = 2'd1; dec_op_sel = 3'd0;
        dec_rs1 = 5'd5; dec_rs2 = 5'd7; dec_rd = 5'd3; dec_imm = 32'd3;
        dec_rob_tag = 4'd2; dec_alu_op = 4'd1;
        prod_rs1_valid = 1'b1; rf_rs1_value = 32'h10; rs_ready = 1'b1;
        #1;
        chk("addi_dec_ready", 64'(dec_ready), 64'd1);
        chk("addi_rs1_addr",  64'(rs1_addr),  64'd5);
        step();
        dec_valid = 1'b0;
        chk("addi_disp_valid", 64'(disp_valid),     64'd1);
        chk("addi_rs1_val",    64'(disp_rs1_value), 64'h10);
        chk("addi_rs1_rdy",    64'(disp_rs1_rdy),   64'd1);
        chk("addi_rs2_val",    64'(disp_rs2_value), 64'd3);
        chk("addi_rs2_rdy",    64'(disp_rs2_rdy),   64'd1);
        chk("addi_prod_en",    64'(prod_en),        64'd1);
        chk("addi_prod_rd",    64'(prod_rd),        64'd3);
        chk("addi_prod_tag",   64'(prod_tag),       64'd2);
        chk("addi_rob_wr_en",  64'(rob_wr_en),      64'd0);
        chk("addi_alu_op",     64'(disp_alu_op),    64'd1);
        step();
        chk("addi_drop_valid", 64'(disp_valid), 64'd0);
        chk("addi_prod_pulse", 64'(prod_en),    64'd0);

        // R-type with rs2 waiting on tag 6
        clr_inputs();
        dec_valid = 1'b1; dec_fu_sel = 2'd1; dec_op_sel = 3'd1;
        dec_rs1 = 5'd1; dec_rs2 = 5'd2; dec_rd = 5'd4; dec_rob_tag = 4'd5;
        prod_rs1_valid = 1'b1; rf_rs1_value = 32'h11;
        prod_rs2_tag = 4'd6;
        step();
        dec_valid = 1'b0;
        chk("r_disp_valid", 64'(disp_valid),     64'd1);
        chk("r_rs1_val",    64'(disp_rs1_value), 64'h11);
        chk("r_rs2_rdy",    64'(disp_rs2_rdy),   64'd0);
        chk("r_rs2_q",      64'(disp_rs2_q),     64'd6);
        chk("r_tag",        64'(disp_tag),       64'd5);
        step();
        chk("r_hold_rdy",   64'(disp_rs2_rdy), 64'd0);
        chk("r_hold_ready", 64'(dec_ready),    64'd0);
        cdb_valid = 2'b10; cdb_tag = {4'd6, 4'd0}; cdb_value = {32'hAB, 32'h0};
        step();
        cdb_valid = '0;
        chk("r_snoop_val",   64'(disp_rs2_value), 64'hAB);
        chk("r_snoop_rdy",   64'(disp_rs2_rdy),   64'd1);
        chk("r_still_valid", 64'(disp_valid),     64'd1);
        rs_ready = 1'b1;
        #1;
        chk("r_accept_ready", 64'(dec_ready), 64'd1);
        step();
        chk("r_accept_valid", 64'(disp_valid), 64'd0);

        // Both CDBs carry tag 3 at capture: bus 0 wins
        clr_inputs();
        dec_valid = 1'b1; dec_fu_sel = 2'd1; dec_op_sel = 3'd1;
        dec_rs1 = 5'd0; dec_rs2 = 5'd9; dec_rd = 5'd8; dec_rob_tag = 4'd9;
        rf_rs1_value = 32'h77; prod_rs1_valid = 1'b1;
        prod_rs2_tag = 4'd3;
        cdb_valid = 2'b11; cdb_tag = {4'd3, 4'd3}; cdb_value = {32'h22, 32'h11};
        step();
        dec_valid = 1'b0; cdb_valid = '0;
        chk("cdb_pri_val", 64'(disp_rs2_value), 64'h11);
        chk("cdb_pri_rdy", 64'(disp_rs2_rdy),   64'd1);
        chk("x0_rs1_val",  64'(disp_rs1_value), 64'd0);
        rs_ready = 1'b1;
        step();

        // AUIPC: fu NONE, rob bypass pc+imm
        clr_inputs();
        dec_valid = 1'b1; dec_fu_sel = 2'd0; dec_op_sel = 3'd0;
        dec_pc = 32'h100; dec_imm = 32'h2000; dec_rs1 = 5'd0;
        dec_rd = 5'd6; dec_rob_tag = 4'd7;
        step();
        dec_valid = 1'b0;
        chk("auipc_rob_en",    64'(rob_wr_en),    64'd1);
        chk("auipc_rob_val",   64'(rob_wr_value), 64'h2100);
        chk("auipc_rob_dest",  64'(rob_wr_dest),  64'd6);
        chk("auipc_disp_vld",  64'(disp_valid),   64'd0);
        step();
        chk("auipc_rob_pulse", 64'(rob_wr_en),    64'd0);

        // JAL to the branch unit
        clr_inputs();
        dec_valid = 1'b1; dec_fu_sel = 2'd2; dec_op_sel = 3'd2;
        dec_pc = 32'h40; dec_imm = 32'h80; dec_rd = 5'd1; dec_rob_tag = 4'd3;
        step();
        dec_valid = 1'b0;
        chk("jal_rob_en",   64'(rob_wr_en),      64'd1);
        chk("jal_rob_val",  64'(rob_wr_value),   64'h44);
        chk("jal_rs1_val",  64'(disp_rs1_value), 64'h40);
        chk("jal_rs1_rdy",  64'(disp_rs1_rdy),   64'd1);
        chk("jal_disp_vld", 64'(disp_valid),     64'd1);
        br_ready = 1'b1;
        step();

        // STORE with rs2=x0, then back-pressure and flush
        clr_inputs();
        dec_valid = 1'b1; dec_fu_sel = 2'd3; dec_op_sel = 3'd6;
        dec_rs1 = 5'd2; dec_rs2 = 5'd0; dec_rd = 5'd5; dec_imm = 32'h8;
        prod_rs1_valid = 1'b1; rf_rs1_value = 32'h1000;
        step();
        chk("st_rs2_val",   64'(disp_rs2_value), 64'd0);
        chk("st_rs2_rdy",   64'(disp_rs2_rdy),   64'd1);
        chk("st_offset",    64'(disp_offset),    64'h8);
        chk("st_prod_en",   64'(prod_en),        64'd0);
        chk("st_rs1_val",   64'(disp_rs1_value), 64'h1000);
        // Next instruction (LOAD) must stall behind the held store
        dec_op_sel = 3'd5; dec_imm = 32'h30; dec_rd = 5'd12;
        #1;
        chk("b2b_dec_ready", 64'(dec_ready), 64'd0);
        step();
        chk("b2b_held_off",  64'(disp_offset), 64'h8);
        chk("b2b_prod_en",   64'(prod_en),     64'd0);
        flush = 1'b1;
        #1;
        chk("flush_dec_ready", 64'(dec_ready), 64'd0);
        step();
        chk("flush_valid",   64'(disp_valid), 64'd0);
        chk("flush_prod_en", 64'(prod_en),    64'd0);
        chk("flush_rob_en",  64'(rob_wr_en),  64'd0);
        flush = 1'b0; dec_valid = 1'b0;
        step();

        // BRANCH, then reset mid-hold
        clr_inputs();
        dec_valid = 1'b1; dec_fu_sel = 2'd2; dec_op_sel = 3'd4;
        dec_pc = 32'h200; dec_rs1 = 5'd3; dec_rs2 = 5'd4; dec_rd = 5'd7;
        dec_imm = 32'h10; dec_rob_tag = 4'd11;
        prod_rs1_valid = 1'b1; rf_rs1_value = 32'h5;
        rob_rs2_valid = 1'b1; rob_rs2_value = 32'h6;
        step();
        dec_valid = 1'b0;
        chk("br_comp",      64'(disp_br_comp),   64'd1);
        chk("br_prod_en",   64'(prod_en),        64'd0);
        chk("br_offset",    64'(disp_offset),    64'h10);
        chk("br_rs2_rob",   64'(disp_rs2_value), 64'h6);
        chk("br_pc",        64'(disp_pc),        64'h200);
        chk("br_disp_vld",  64'(disp_valid),     64'd1);
        rst = 1'b0;
        step();
        chk("mrst_valid",     64'(disp_valid),     64'd0);
        chk("mrst_br_comp",   64'(disp_br_comp),   64'd0);
        chk("mrst_offset",    64'(disp_offset),    64'd0);
        chk("mrst_rs1_val",   64'(disp_rs1_value), 64'd0);
        chk("mrst_pc",        64'(disp_pc),        64'd0);
        chk("mrst_rs1_addr",  64'(rs1_addr),       64'd0);
        chk("mrst_dec_ready", 64'(dec_ready),      64'd0);
        rst = 1'b1;
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
